// File: rtl/seg7_time_display.sv
// rtl/seg7_time_display.sv - multiplexed 6-digit 7-segment time display (optional macro: CURSOR_BLINK_EN)
module seg7_time_display #(
    parameter int SCAN_DIV  = 50_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] H1,
    input  logic [3:0] H0,
    input  logic [3:0] M1,
    input  logic [3:0] M0,
    input  logic [3:0] S1,
    input  logic [3:0] S0,
    input  logic [2:0] cursor,
    input  logic       edit_mode,
    output logic [7:0] seg_n,
    output logic [5:0] an_n
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [SW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic [3:0]    digit;
    logic [6:0]    seg_lo;
    logic          dp;
    logic          slot_blank;
    logic [5:0]    an_next;
    logic [7:0]    seg_next;
    logic          scan_wrap;

    assign scan_wrap = (scan_cnt == SCAN_LAST);

`ifdef CURSOR_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_ph;

    // Blink phase generator; advances only while the display is enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (en) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`endif

    // Select the digit for the current slot, decode it and decide dots / blanking
    always_comb begin
        digit = S0;
        case (idx)
            3'd0:    digit = S0;
            3'd1:    digit = S1;
            3'd2:    digit = M0;
            3'd3:    digit = M1;
            3'd4:    digit = H0;
            3'd5:    digit = H1;
            default: digit = S0;
        endcase

        seg_lo = 7'b0111111;
        case (digit)
            4'd0:    seg_lo = 7'b1000000;
            4'd1:    seg_lo = 7'b1111001;
            4'd2:    seg_lo = 7'b0100100;
            4'd3:    seg_lo = 7'b0110000;
            4'd4:    seg_lo = 7'b0011001;
            4'd5:    seg_lo = 7'b0010010;
            4'd6:    seg_lo = 7'b0000010;
            4'd7:    seg_lo = 7'b1111000;
            4'd8:    seg_lo = 7'b0000000;
            4'd9:    seg_lo = 7'b0010000;
            default: seg_lo = 7'b0111111;
        endcase

        // separator dots between HH.MM.SS sit on H0 and M0
        dp = !((idx == 3'd2) || (idx == 3'd4));
        // last count of each slot is an all-off gap so the previous digit does not ghost
        slot_blank = scan_wrap;
`ifdef CURSOR_BLINK_EN
        if (edit_mode && blink_ph && (idx == cursor))
            slot_blank = 1'b1;
`else
        if (edit_mode && (idx == cursor))
            dp = 1'b0;
`endif

        if (slot_blank) begin
            an_next  = 6'b111111;
            seg_next = 8'hFF;
        end else begin
            an_next  = ~(6'b000001 << idx);
            seg_next = {dp, seg_lo};
        end
    end

    // Slot timer and digit index; both freeze while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
        end else if (en) begin
            if (scan_wrap) begin
                scan_cnt <= '0;
                idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    // Registered display drive; disabled display is fully dark
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            an_n  <= 6'b111111;
            seg_n <= 8'hFF;
        end else begin
            an_n  <= an_next;
            seg_n <= seg_next;
        end
    end

endmodule
